// File: rtl/stream_arb4_rr.sv
// -----------------------------------------------------------------------------
// stream_arb4_rr
//
// Round-robin arbiter that merges four valid/ready producers into a single
// registered output stream. It produces the 2-bit select code of the winning
// requester alongside the captured word, and sustains one word per cycle
// when the consumer keeps out_ready_i high.
//
// Ports:
//   clk_i        - system clock, all state updates on the rising edge
//   rst_i        - synchronous, active-high reset
//   in1_i..in4_i - data words from requesters 0..3
//   valid_i[k]   - requester k presents a word
//   ready_o[k]   - requester k's word is accepted this cycle (combinational,
//                  at most one bit set)
//   out_data_o   - registered selected word
//   out_valid_o  - out_data_o holds an unconsumed word
//   out_ready_i  - consumer takes out_data_o when high with out_valid_o
//   sel_o        - registered index of the requester that supplied out_data_o
// -----------------------------------------------------------------------------
module stream_arb4_rr #(
    parameter int Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] in1_i,
    input  logic [Width-1:0] in2_i,
    input  logic [Width-1:0] in3_i,
    input  logic [Width-1:0] in4_i,
    input  logic [3:0]       valid_i,
    output logic [3:0]       ready_o,
    output logic [Width-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [1:0]       sel_o
);

    logic [Width-1:0] r_data_p1;
    logic             r_vld_p1;
    logic [1:0]       r_sel_p1;
    logic [1:0]       r_ptr;

    logic             w_can_accept;
    logic             w_gnt_found;
    logic [1:0]       w_gnt_idx;
    logic [1:0]       w_scan_idx;
    logic             w_accept;
    logic [Width-1:0] w_mux_data;

    // The output register can take a new word when it is empty or is being
    // drained on this same edge.
    assign w_can_accept = ~r_vld_p1 | out_ready_i;

    // Scan from the farthest offset down to offset 0 so that the requester
    // closest to the pointer is the last one written and therefore wins.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = 2'd0;
        w_scan_idx  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            w_scan_idx = r_ptr + 2'(i);
            if (valid_i[w_scan_idx]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_scan_idx;
            end
        end
    end

    assign w_accept = w_gnt_found & w_can_accept;

    always_comb begin
        ready_o = 4'b0000;
        if (w_accept) begin
            ready_o[w_gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        case (w_gnt_idx)
            2'd0:    w_mux_data = in1_i;
            2'd1:    w_mux_data = in2_i;
            2'd2:    w_mux_data = in3_i;
            default: w_mux_data = in4_i;
        endcase
    end

    // ---- stage p0 -> p1: capture the granted word ----
    // Reset also clears the data register so a discarded word never leaks out.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vld_p1  <= 1'b0;
            r_data_p1 <= '0;
            r_sel_p1  <= 2'd0;
            r_ptr     <= 2'd0;
        end else if (w_accept) begin
            r_vld_p1  <= 1'b1;
            r_data_p1 <= w_mux_data;
            r_sel_p1  <= w_gnt_idx;
            r_ptr     <= w_gnt_idx + 2'd1;
        end else if (out_ready_i) begin
            // Drained with nothing to refill; data and select keep last values.
            r_vld_p1  <= 1'b0;
        end
    end

    assign out_data_o  = r_data_p1;
    assign out_valid_o = r_vld_p1;
    assign sel_o       = r_sel_p1;

endmodule

// File: tb/tb_stream_arb4_rr.sv
module tb_stream_arb4_rr;

    localparam int Width = 32;

    logic             clk_i;
    logic             rst_i;
    logic [Width-1:0] in1_i, in2_i, in3_i, in4_i;
    logic [3:0]       valid_i;
    logic [3:0]       ready_o;
    logic [Width-1:0] out_data_o;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [1:0]       sel_o;

    int checks = 0;
    int errors = 0;

    // Expected output words, in consumption order: {sel, data}
    logic [Width+1:0] exp_q[$];

    stream_arb4_rr #(.Width(Width)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in1_i       (in1_i),
        .in2_i       (in2_i),
        .in3_i       (in3_i),
        .in4_i       (in4_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .sel_o       (sel_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [1:0] s, input logic [Width-1:0] d);
        exp_q.push_back({s, d});
    endtask

    // Monitor: at the falling edge a word with valid&ready is consumed on the
    // next rising edge, so each such sample is exactly one transfer.
    always @(negedge clk_i) begin
        logic [Width+1:0] e;
        if (!rst_i && out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got sel %0d data %0h expected none", sel_o, out_data_o);
            end else begin
                e = exp_q.pop_front();
                chk("mon_sel", 64'(sel_o), 64'(e[Width+1:Width]));
                chk("mon_data", 64'(out_data_o), 64'(e[Width-1:0]));
            end
        end
    end

    initial begin
        rst_i = 1'b1;
        valid_i = 4'b0000;
        out_ready_i = 1'b0;
        in1_i = '0; in2_i = '0; in3_i = '0; in4_i = '0;
        cyc();
        cyc();
        rst_i = 1'b0;

        // 1. reset state and idle
        out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("idle_valid", 64'(out_valid_o), 64'd0);
            chk("idle_data", 64'(out_data_o), 64'd0);
            chk("idle_sel", 64'(sel_o), 64'd0);
            chk("idle_ready", 64'(ready_o), 64'b0000);
            cyc();
        end

        // 2. single requester, then pointer moves past it
        in3_i = 32'hA5A5_0003;
        in4_i = 32'h4444_0004;
        valid_i = 4'b0100;
        #1;
        chk("single_ready", 64'(ready_o), 64'b0100);
        push(2'd2, 32'hA5A5_0003);
        cyc();
        chk("single_valid", 64'(out_valid_o), 64'd1);
        chk("single_data", 64'(out_data_o), 64'hA5A5_0003);
        chk("single_sel", 64'(sel_o), 64'd2);
        valid_i = 4'b1100;
        #1;
        chk("ptr3_ready", 64'(ready_o), 64'b1000);
        push(2'd3, 32'h4444_0004);
        cyc();
        valid_i = 4'b0000;
        cyc();
        chk("drain_valid", 64'(out_valid_o), 64'd0);
        chk("drain_hold_sel", 64'(sel_o), 64'd3);

        // 3. full contention, back to back
        in1_i = 32'd1; in2_i = 32'd2; in3_i = 32'd3; in4_i = 32'd4;
        valid_i = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("rr_ready", 64'(ready_o), 64'(4'b0001 << (i % 4)));
            push(2'(i % 4), 32'((i % 4) + 1));
            cyc();
            chk("rr_valid", 64'(out_valid_o), 64'd1);
            chk("rr_sel", 64'(sel_o), 64'(i % 4));
        end

        // 4. backpressure after first accept
        #1;
        chk("bp_first_ready", 64'(ready_o), 64'b0001);
        push(2'd0, 32'd1);
        cyc();
        out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready", 64'(ready_o), 64'b0000);
            cyc();
            chk("bp_valid", 64'(out_valid_o), 64'd1);
            chk("bp_data", 64'(out_data_o), 64'd1);
            chk("bp_sel", 64'(sel_o), 64'd0);
        end
        out_ready_i = 1'b1;
        #1;
        chk("bp_release_ready", 64'(ready_o), 64'b0010);
        push(2'd1, 32'd2);
        cyc();
        chk("bp_release_sel", 64'(sel_o), 64'd1);

        // 5. wrap-around: grant 3, then 0 beats 3
        valid_i = 4'b1000;
        #1;
        chk("wrap_g3_ready", 64'(ready_o), 64'b1000);
        push(2'd3, 32'd4);
        cyc();
        valid_i = 4'b1001;
        #1;
        chk("wrap_ready", 64'(ready_o), 64'b0001);
        push(2'd0, 32'd1);
        cyc();
        valid_i = 4'b0000;
        cyc();
        cyc();

        // 6. reset while a word is held under backpressure (word is discarded)
        out_ready_i = 1'b0;
        valid_i = 4'b0010;
        #1;
        chk("mid_fill_ready", 64'(ready_o), 64'b0010);
        cyc();
        chk("mid_held_valid", 64'(out_valid_o), 64'd1);
        chk("mid_stall_ready", 64'(ready_o), 64'b0000);
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        chk("mid_rst_valid", 64'(out_valid_o), 64'd0);
        chk("mid_rst_sel", 64'(sel_o), 64'd0);
        chk("mid_rst_data", 64'(out_data_o), 64'd0);
        valid_i = 4'b1111;
        out_ready_i = 1'b1;
        #1;
        chk("post_rst_ready", 64'(ready_o), 64'b0001);
        push(2'd0, 32'd1);
        cyc();
        valid_i = 4'b0000;
        cyc();
        cyc();

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
